// File: rtl/spike_winner_readout_if.sv
// Bundle of spike inputs, window control and classification results
// shared between a spike source (master) and the winner readout (slave).
interface spike_winner_readout_if #(
  parameter int unsigned NUM_SPIKES = 10,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned WINDOW_W   = 10
);
  logic [NUM_SPIKES-1:0] spike_i;
  logic [WINDOW_W-1:0]   window_len_i;
  logic                  start_i;
  logic                  busy_o;
  logic                  valid_o;
  logic [3:0]            winner_o;
  logic [CNT_W-1:0]      winner_count_o;
  logic                  tie_o;
  logic                  none_o;

  modport master (
    output spike_i, window_len_i, start_i,
    input  busy_o, valid_o, winner_o, winner_count_o, tie_o, none_o
  );

  modport slave (
    input  spike_i, window_len_i, start_i,
    output busy_o, valid_o, winner_o, winner_count_o, tie_o, none_o
  );
endinterface

// File: rtl/spike_winner_readout.sv
// Integrates output-layer spikes over a window, then scans the saturating
// counters one neuron per cycle to report the winning index.
module spike_winner_readout #(
  parameter int unsigned NUM_SPIKES = 10,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned WINDOW_W   = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  spike_winner_readout_if.slave  bus
);

  localparam int unsigned IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPIKES - 1);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    COMPARE,
    DONE
  } state_e;

  state_e              state_q;
  logic [WINDOW_W-1:0] remain_q;
  logic [CNT_W-1:0]    cnt_q [NUM_SPIKES];
  logic [IDX_W-1:0]    scan_idx_q;
  logic [IDX_W-1:0]    max_idx_q;
  logic [CNT_W-1:0]    max_q;
  logic                tie_q;

  logic [CNT_W-1:0]    scan_cnt_d;
  logic [CNT_W-1:0]    max_d;
  logic [IDX_W-1:0]    max_idx_d;
  logic                tie_d;

  // One scan step: the first neuron seeds the maximum, later ones replace it
  // only when strictly greater so equal counts keep the lowest index.
  always_comb begin
    scan_cnt_d = '0;
    for (int unsigned i = 0; i < NUM_SPIKES; i++) begin
      if (IDX_W'(i) == scan_idx_q) begin
        scan_cnt_d = cnt_q[i];
      end
    end
    max_d     = max_q;
    max_idx_d = max_idx_q;
    tie_d     = tie_q;
    if (scan_idx_q == '0 || scan_cnt_d > max_q) begin
      max_d     = scan_cnt_d;
      max_idx_d = scan_idx_q;
      tie_d     = 1'b0;
    end else if (scan_cnt_d == max_q) begin
      tie_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q            <= IDLE;
      remain_q           <= '0;
      scan_idx_q         <= '0;
      max_idx_q          <= '0;
      max_q              <= '0;
      tie_q              <= 1'b0;
      for (int unsigned i = 0; i < NUM_SPIKES; i++) begin
        cnt_q[i] <= '0;
      end
      bus.busy_o         <= 1'b0;
      bus.valid_o        <= 1'b0;
      bus.winner_o       <= '0;
      bus.winner_count_o <= '0;
      bus.tie_o          <= 1'b0;
      bus.none_o         <= 1'b0;
    end else begin
      bus.valid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            remain_q   <= (bus.window_len_i == '0) ? WINDOW_W'(1) : bus.window_len_i;
            for (int unsigned i = 0; i < NUM_SPIKES; i++) begin
              cnt_q[i] <= '0;
            end
            scan_idx_q <= '0;
            max_idx_q  <= '0;
            max_q      <= '0;
            tie_q      <= 1'b0;
            bus.busy_o <= 1'b1;
            state_q    <= COUNT;
          end
        end
        COUNT: begin
          for (int unsigned i = 0; i < NUM_SPIKES; i++) begin
            if (bus.spike_i[i] && cnt_q[i] != '1) begin
              cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
          end
          if (remain_q == WINDOW_W'(1)) begin
            state_q <= COMPARE;
          end else begin
            remain_q <= remain_q - WINDOW_W'(1);
          end
        end
        COMPARE: begin
          max_q      <= max_d;
          max_idx_q  <= max_idx_d;
          tie_q      <= tie_d;
          scan_idx_q <= scan_idx_q + IDX_W'(1);
          // Last neuron folded in: publish, with an all-zero window reported as none.
          if (scan_idx_q == LAST_IDX) begin
            bus.busy_o         <= 1'b0;
            bus.valid_o        <= 1'b1;
            bus.none_o         <= (max_d == '0);
            bus.winner_o       <= (max_d == '0) ? '0 : max_idx_d;
            bus.winner_count_o <= max_d;
            bus.tie_o          <= tie_d && (max_d != '0);
            state_q            <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_winner_readout.sv
// Self-checking bench: vector table and random windows scored through a
// queue of expected results, plus reset/abort and ignored-start sequences.
module tb_spike_winner_readout;

  localparam int N  = 10;
  localparam int CW = 8;
  localparam int WW = 10;

  typedef struct {
    int winner;
    int count;
    int tie;
    int none;
    int lat;
  } exp_t;

  typedef struct {
    int                  wlen;
    logic [N-1:0][9:0]   on;
    exp_t                exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spike_winner_readout_if #(.NUM_SPIKES(N), .CNT_W(CW), .WINDOW_W(WW)) bus ();

  spike_winner_readout #(.NUM_SPIKES(N), .CNT_W(CW), .WINDOW_W(WW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_spikes(input logic [N-1:0][9:0] on, input int k);
    for (int n = 0; n < N; n++) bus.spike_i[n] = (k < int'(on[n]));
  endtask

  function automatic exp_t model(input int wlen, input logic [N-1:0][9:0] on);
    exp_t e;
    int   weff, mx, idx, num, c;
    weff = (wlen == 0) ? 1 : wlen;
    mx = 0; idx = 0; num = 0;
    for (int n = 0; n < N; n++) begin
      c = int'(on[n]);
      if (c > weff) c = weff;
      if (c > 255) c = 255;
      if (c > mx) begin mx = c; idx = n; num = 1; end
      else if (c == mx && c != 0) num++;
    end
    e.none   = (mx == 0) ? 1 : 0;
    e.winner = (mx == 0) ? 0 : idx;
    e.count  = mx;
    e.tie    = (mx != 0 && num > 1) ? 1 : 0;
    e.lat    = weff + N;
    return e;
  endfunction

  // One full window; mid_start > 0 pulses start_i (new length 5) at that edge.
  task automatic run_window(input int wlen, input logic [N-1:0][9:0] on,
                            input exp_t e, input int mid_start);
    int   weff;
    bit   got;
    exp_t q;
    weff = (wlen == 0) ? 1 : wlen;
    bus.window_len_i = WW'(wlen);
    bus.spike_i      = '0;
    bus.start_i      = 1'b1;
    tick();
    sb.push_back(e);
    bus.start_i = 1'b0;
    chk("busy_after_start", int'(bus.busy_o), 1);
    got = 1'b0;
    for (int ed = 1; ed <= weff + N + 5 && !got; ed++) begin
      drive_spikes(on, ed - 1);
      if (ed == mid_start) begin
        bus.start_i      = 1'b1;
        bus.window_len_i = WW'(5);
      end
      tick();
      bus.start_i = 1'b0;
      if (bus.valid_o) begin
        got = 1'b1;
        chk("latency", ed, e.lat);
        chk("busy_in_done", int'(bus.busy_o), 0);
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL scoreboard: valid with no expected entry");
        end else begin
          q = sb.pop_front();
          chk("winner", int'(bus.winner_o), q.winner);
          chk("winner_count", int'(bus.winner_count_o), q.count);
          chk("tie", int'(bus.tie_o), q.tie);
          chk("none", int'(bus.none_o), q.none);
        end
      end else begin
        chk("busy", int'(bus.busy_o), (ed < weff + N) ? 1 : 0);
      end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL timeout: no valid_o within %0d edges", weff + N + 5);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    bus.spike_i = '0;
    tick();
    chk("valid_drop", int'(bus.valid_o), 0);
    chk("busy_idle", int'(bus.busy_o), 0);
    chk("winner_hold", int'(bus.winner_o), e.winner);
    chk("count_hold", int'(bus.winner_count_o), e.count);
  endtask

  // Start a window, reset at edge abort_edge, confirm no result ever appears.
  task automatic abort_window(input int wlen, input int abort_edge, input bit with_start);
    bit seen;
    bus.window_len_i = WW'(wlen);
    bus.spike_i      = '1;
    bus.start_i      = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int ed = 1; ed < abort_edge; ed++) tick();
    rst         = 1'b1;
    bus.start_i = with_start;
    tick();
    rst         = 1'b0;
    bus.start_i = 1'b0;
    chk("abort_busy", int'(bus.busy_o), 0);
    chk("abort_valid", int'(bus.valid_o), 0);
    chk("abort_winner", int'(bus.winner_o), 0);
    chk("abort_count", int'(bus.winner_count_o), 0);
    chk("abort_tie", int'(bus.tie_o), 0);
    chk("abort_none", int'(bus.none_o), 0);
    seen = 1'b0;
    for (int i = 0; i < wlen + N + 5; i++) begin
      tick();
      if (bus.valid_o || bus.busy_o) seen = 1'b1;
    end
    chk("abort_no_activity", int'(seen), 0);
    bus.spike_i = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0][9:0] on;
    exp_t              e;
    int                wl;

    for (int i = 0; i < 6; i++) tbl[i].on = '0;
    tbl[0].wlen = 4;   tbl[0].on[3] = 10'd1023;
    tbl[0].exp  = '{winner: 3, count: 4,   tie: 0, none: 0, lat: 14};
    tbl[1].wlen = 6;   tbl[1].on[1] = 10'd3; tbl[1].on[5] = 10'd3; tbl[1].on[8] = 10'd2;
    tbl[1].exp  = '{winner: 1, count: 3,   tie: 1, none: 0, lat: 16};
    tbl[2].wlen = 600; tbl[2].on[7] = 10'd1023; tbl[2].on[2] = 10'd300;
    tbl[2].exp  = '{winner: 2, count: 255, tie: 1, none: 0, lat: 610};
    tbl[3].wlen = 8;
    tbl[3].exp  = '{winner: 0, count: 0,   tie: 0, none: 1, lat: 18};
    tbl[4].wlen = 0;   tbl[4].on[9] = 10'd1023;
    tbl[4].exp  = '{winner: 9, count: 1,   tie: 0, none: 0, lat: 11};
    tbl[5].wlen = 5;   tbl[5].on[2] = 10'd2; tbl[5].on[4] = 10'd2; tbl[5].on[6] = 10'd3;
    tbl[5].exp  = '{winner: 6, count: 3,   tie: 0, none: 0, lat: 15};

    rst              = 1'b1;
    bus.spike_i      = '0;
    bus.window_len_i = '0;
    bus.start_i      = 1'b0;
    tick();
    tick();
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_valid", int'(bus.valid_o), 0);
    chk("rst_winner", int'(bus.winner_o), 0);
    chk("rst_count", int'(bus.winner_count_o), 0);
    chk("rst_tie", int'(bus.tie_o), 0);
    chk("rst_none", int'(bus.none_o), 0);

    // Reset wins over a simultaneous start.
    bus.start_i      = 1'b1;
    bus.window_len_i = WW'(3);
    tick();
    rst         = 1'b0;
    bus.start_i = 1'b0;
    chk("rst_over_start", int'(bus.busy_o), 0);
    tick();
    chk("rst_over_start_idle", int'(bus.busy_o), 0);

    for (int i = 0; i < 6; i++) run_window(tbl[i].wlen, tbl[i].on, tbl[i].exp, 0);

    for (int r = 0; r < 4; r++) begin
      wl = int'($urandom_range(1, 40));
      for (int n = 0; n < N; n++) on[n] = 10'($urandom_range(0, 45));
      on[int'($urandom_range(0, 4))] = on[int'($urandom_range(5, 9))];
      e = model(wl, on);
      run_window(wl, on, e, 0);
    end

    // Reset mid-COUNT and mid-COMPARE (the latter with start asserted too).
    abort_window(20, 7, 1'b0);
    abort_window(4, 8, 1'b1);

    // start_i during COMPARE is ignored: same timing and result, no restart.
    on = '0;
    on[0] = 10'd1023;
    e = '{winner: 0, count: 3, tie: 0, none: 0, lat: 13};
    run_window(3, on, e, 5);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_queued_start", int'(bus.busy_o), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spike_winner_readout.md
SPIKE_WINNER_READOUT -- requirements
Module: spike_winner_readout

Interface
REQ-001 SHALL have parameter NUM_SPIKES, default 10, number of output-layer spike lines.
REQ-002 SHALL have parameter CNT_W, default 8, width of each per-neuron spike counter.
REQ-003 SHALL have parameter WINDOW_W, default 10, width of the window-length input.
REQ-004 SHALL have port clk_i, input, 1, sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port spike_i, input, NUM_SPIKES, one spike bit per output neuron per cycle.
REQ-007 SHALL have port window_len_i, input, WINDOW_W, number of cycles to integrate; sampled on start.
REQ-008 SHALL have port start_i, input, 1, request to begin one classification window.
REQ-009 SHALL have port busy_o, output, 1, high while a window is counting or being compared.
REQ-010 SHALL have port valid_o, output, 1, single-cycle pulse marking new results.
REQ-011 SHALL have port winner_o, output, 4, index of the neuron with the highest count.
REQ-012 SHALL have port winner_count_o, output, CNT_W, count of the winning neuron.
REQ-013 SHALL have port tie_o, output, 1, more than one neuron shares the nonzero maximum.
REQ-014 SHALL have port none_o, output, 1, all counts zero in the window.

Function
REQ-015 SHALL implement FSM states IDLE, COUNT, COMPARE, DONE; reset state IDLE.
REQ-016 IDLE: start_i high at edge E0 SHALL latch window_len_i, clear all counters, clear the scan index, enter COUNT.
REQ-017 A window_len_i of 0 SHALL be treated as 1.
REQ-018 start_i SHALL be ignored in COUNT, COMPARE and DONE; no restart, no queuing.
REQ-019 COUNT: spike_i SHALL be sampled at edges E1..EW, W the latched length; each set bit increments its counter.
REQ-020 Counters SHALL saturate at 2^CNT_W-1; further spikes leave them unchanged.
REQ-021 After edge EW the FSM SHALL enter COMPARE; spike_i outside COUNT SHALL have no effect.
REQ-022 COMPARE: one neuron per edge, index 0 to NUM_SPIKES-1, at edges EW+1..EW+NUM_SPIKES.
REQ-023 Scan SHALL replace the running maximum only on strictly greater count; equal count sets the running tie flag.
REQ-024 A strictly greater count SHALL clear the running tie flag.
REQ-025 Equal counts SHALL resolve to the lowest index.
REQ-026 At edge EW+NUM_SPIKES, winner_o, winner_count_o, tie_o and none_o SHALL update, valid_o SHALL go to 1 and the FSM SHALL enter DONE.
REQ-027 none_o SHALL be 1 iff the maximum is 0; then winner_o=0, winner_count_o=0, tie_o=0.
REQ-028 DONE SHALL last one cycle; the next edge SHALL set valid_o=0 and return to IDLE.
REQ-029 Result outputs SHALL hold their values until the next DONE update.
REQ-030 busy_o SHALL be 1 from edge E0 through edge EW+NUM_SPIKES-1 (COUNT and COMPARE states); 0 in IDLE and DONE.
REQ-031 Total latency from the start edge to valid_o SHALL be W+NUM_SPIKES edges.
REQ-032 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-033 rst_i high at any edge SHALL force IDLE, clear all counters, scan state and latched length.
REQ-034 Reset SHALL set busy_o=0, valid_o=0, winner_o=0, winner_count_o=0, tie_o=0, none_o=0.
REQ-035 Reset SHALL take priority over start_i and all FSM activity, including mid-COUNT and mid-COMPARE.
REQ-036 An aborted window SHALL produce no valid_o pulse.

Verification
REQ-037 W=4, spike_i[3]=1 every cycle, others 0 -> valid_o at edge E14, winner_o=3, winner_count_o=4, tie_o=0, none_o=0.
REQ-038 W=6, spike_i[1] and spike_i[5] each high 3 cycles, spike_i[8] high 2 cycles -> winner_o=1, winner_count_o=3, tie_o=1.
REQ-039 W=600, spike_i[7] constant, spike_i[2] high first 300 cycles -> both saturate: winner_o=2, winner_count_o=255, tie_o=1.
REQ-040 W=8, spike_i=0 -> none_o=1, winner_o=0, winner_count_o=0, tie_o=0, valid_o at edge E18.
REQ-041 W=0, spike_i[9]=1 -> treated as W=1: winner_o=9, winner_count_o=1, valid_o at edge E11.
REQ-042 rst_i pulsed in COUNT, start_i pulsed in COMPARE -> busy_o=0 and all outputs 0 on the next edge, no valid_o; the mid-COMPARE start is ignored and busy_o timing is unchanged.
